// File: rtl/fifo_rd_streamer_if.sv
// Valid/ready word stream between fifo_rd_streamer (master) and its consumer (slave).
interface fifo_rd_streamer_if #(
    parameter int FIFO_WIDTH = 16
);
    logic                  m_valid;
    logic                  m_ready;
    logic [FIFO_WIDTH-1:0] m_data;

    modport master (
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/fifo_rd_streamer.sv
// Drains a registered-output FIFO into a valid/ready stream through a 3-entry skid buffer.
// Optional statistics counters are built only when STREAM_STATS_EN is defined.
module fifo_rd_streamer #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    fifo_rd_streamer_if.master    m,
    output logic                  busy,
    output logic                  err_underflow,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [FIFO_WIDTH-1:0] slot [3];
    logic [1:0]            head;
    logic [1:0]            tail;
    logic [1:0]            occ;
    logic                  inflight;
    logic                  rd_en;
    logic                  pop;
    logic                  capture;
    logic                  drained;

    function automatic logic [1:0] wrap_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Credit check counts the word already in flight, so the buffer can never overflow
    // and the read request never depends on m_ready.
    assign rd_en      = (state == RUN) && !fifo_empty
                        && (({1'b0, occ} + {2'b00, inflight}) < 3'd3);
    assign fifo_rd_en = rd_en;
    assign capture    = inflight;
    assign pop        = m.m_valid && m.m_ready;
    assign drained    = (occ == 2'd0) && !inflight;
    assign m.m_valid  = (occ != 2'd0);
    assign m.m_data   = slot[head];
    assign busy       = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (en) state_next = RUN;
            end
            RUN: begin
                if (!en) state_next = drained ? IDLE : HALT;
            end
            HALT: begin
                if (en)           state_next = RUN;
                else if (drained) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
            for (int unsigned i = 0; i < 3; i++) slot[i] <= '0;
        end else begin
            state    <= state_next;
            inflight <= rd_en;
            if (capture) begin
                slot[tail] <= fifo_data_out;
                tail       <= wrap_inc(tail);
            end
            if (pop) head <= wrap_inc(head);
            case ({capture, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Underflow raised by some other reader of the same FIFO is not our error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     err_underflow <= 1'b0;
        else if (fifo_underflow && rd_en) err_underflow <= 1'b1;
    end

`ifdef STREAM_STATS_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] words_q;
    logic [CNT_WIDTH-1:0] stalls_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_q  <= '0;
            stalls_q <= '0;
        end else begin
            if (pop && (words_q != '1))
                words_q <= words_q + CNT_ONE;
            if (m.m_valid && !m.m_ready && (stalls_q != '1))
                stalls_q <= stalls_q + CNT_ONE;
        end
    end

    assign word_cnt  = words_q;
    assign stall_cnt = stalls_q;
`else
    assign word_cnt  = '0;
    assign stall_cnt = '0;
`endif

endmodule
